// File: rtl/sdram_fb_pkg.sv
// Shared frame-buffer definitions for the SDRAM line writer and the display line reader.
package sdram_fb_pkg;

  localparam int ADDR_COL_LSB  = 0;
  localparam int ADDR_COL_MSB  = 10;
  localparam int ADDR_ROW_LSB  = 11;
  localparam int ADDR_ROW_MSB  = 21;
  localparam int ADDR_BANK_LSB = 22;
  localparam int ADDR_BANK_MSB = 23;

  localparam logic [10:0] H_PIXELS_DEF = 11'd800;
  localparam logic [10:0] V_LINES_DEF  = 11'd600;

  typedef logic [15:0] pixel_t;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_LINE_BEGIN = 2'd1,
    S_LINE_WRITE = 2'd2,
    S_LINE_END   = 2'd3
  } lw_state_e;

endpackage

// File: rtl/m_sdram_line_writer_if.sv
// Word/address bus from the line writer (master) to the SDRAM controller (slave).
interface m_sdram_line_writer_if;
  import sdram_fb_pkg::*;

  pixel_t      DATA;
  logic [23:0] DATA_addr;
  logic        DATA_out_valid;
  logic        DATA_ack;
  logic        Serial_access;

  modport master (
    output DATA, DATA_addr, DATA_out_valid, Serial_access,
    input  DATA_ack
  );

  modport slave (
    input  DATA, DATA_addr, DATA_out_valid, Serial_access,
    output DATA_ack
  );
endinterface

// File: rtl/m_pixel_fifo.sv
// Synchronous pixel FIFO; head word is read from registers, so a push is visible next cycle.
module m_pixel_fifo
  import sdram_fb_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  logic   pop,
  input  pixel_t din,
  output pixel_t dout,
  output logic   full,
  output logic   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push_s, do_pop_s;
  pixel_t        mem_q [DEPTH];

  // pointer and occupancy update; push into a full FIFO is allowed only alongside a pop
  always_comb begin
    do_pop_s  = pop && (count_q != {(AW+1){1'b0}});
    do_push_s = push && ((count_q != FULL_CNT) || do_pop_s);
    wr_ptr_d  = do_push_s ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d  = do_pop_s  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // pointer and occupancy registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {AW{1'b0}};
      rd_ptr_q <= {AW{1'b0}};
      count_q  <= {(AW+1){1'b0}};
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage array
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= din;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == {(AW+1){1'b0}});
endmodule

// File: rtl/m_sdram_line_writer.sv
// Streams raster pixels from a FIFO into one SDRAM bank as one serial burst per line.
module m_sdram_line_writer
  import sdram_fb_pkg::*;
#(
  parameter logic [10:0] H_PIXELS   = H_PIXELS_DEF,
  parameter logic [10:0] V_LINES    = V_LINES_DEF,
  parameter logic [1:0]  SDRAM_BANK = 2'd0,
  parameter int          FIFO_DEPTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  frame_start,
  input  pixel_t                pix_data,
  input  logic                  pix_valid,
  output logic                  pix_ready,
  output logic                  frame_done,
  m_sdram_line_writer_if.master bus
);
  lw_state_e   state_q, state_d;
  logic [10:0] row_q, row_d, col_q, col_d;
  logic        serial_q, serial_d, frame_done_q, frame_done_d;
  logic        restart_s, xfer_s, out_valid_s, fifo_rst_s, fifo_push_s;
  logic        fifo_full_s, fifo_empty_s;
  logic [23:0] addr_s;
  pixel_t      fifo_dout_s;

  // a frame_start mid-frame flushes everything queued for the old frame
  assign restart_s   = frame_start && (state_q != S_IDLE);
  assign fifo_rst_s  = rst || restart_s;
  assign xfer_s      = out_valid_s && bus.DATA_ack;
  assign fifo_push_s = pix_valid && pix_ready;

  m_pixel_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (fifo_rst_s),
    .push  (fifo_push_s),
    .pop   (xfer_s),
    .din   (pix_data),
    .dout  (fifo_dout_s),
    .full  (fifo_full_s),
    .empty (fifo_empty_s)
  );

  // state, counter and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      row_q        <= 11'd0;
      col_q        <= 11'd0;
      serial_q     <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      col_q        <= col_d;
      serial_q     <= serial_d;
      frame_done_q <= frame_done_d;
    end
  end

  // next state and row/col counters
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    if (restart_s) begin
      state_d = S_LINE_BEGIN;
      row_d   = 11'd0;
      col_d   = 11'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (frame_start) begin
            state_d = S_LINE_BEGIN;
            row_d   = 11'd0;
            col_d   = 11'd0;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_LINE_BEGIN: begin
          col_d   = 11'd0;
          state_d = S_LINE_WRITE;
        end
        S_LINE_WRITE: begin
          // col parks at H_PIXELS-1 rather than stepping past the line
          if (xfer_s && (col_q == H_PIXELS - 11'd1)) begin
            state_d = S_LINE_END;
          end else if (xfer_s) begin
            col_d = col_q + 11'd1;
          end else begin
            col_d = col_q;
          end
        end
        S_LINE_END: begin
          if (row_q == V_LINES - 11'd1) begin
            row_d   = 11'd0;
            state_d = S_IDLE;
          end else begin
            row_d   = row_q + 11'd1;
            state_d = S_LINE_BEGIN;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // outputs; DATA/DATA_addr read as zero whenever no word is offered
  always_comb begin
    out_valid_s  = (state_q == S_LINE_WRITE) && !fifo_empty_s;
    pix_ready    = !fifo_full_s && (state_q != S_IDLE);
    serial_d     = serial_q;
    frame_done_d = 1'b0;
    if (restart_s) begin
      serial_d = 1'b0;
    end else begin
      case (state_q)
        S_LINE_BEGIN: serial_d = 1'b1;
        S_LINE_END: begin
          serial_d     = 1'b0;
          frame_done_d = (row_q == V_LINES - 11'd1);
        end
        default: serial_d = serial_q;
      endcase
    end
    addr_s = 24'h000000;
    addr_s[ADDR_BANK_MSB:ADDR_BANK_LSB] = SDRAM_BANK;
    addr_s[ADDR_ROW_MSB:ADDR_ROW_LSB]   = row_q;
    addr_s[ADDR_COL_MSB:ADDR_COL_LSB]   = col_q;
  end

  assign bus.DATA           = out_valid_s ? fifo_dout_s : 16'h0000;
  assign bus.DATA_addr      = out_valid_s ? addr_s : 24'h000000;
  assign bus.DATA_out_valid = out_valid_s;
  assign bus.Serial_access  = serial_q;
  assign frame_done         = frame_done_q;
endmodule

// File: tb/tb_m_sdram_line_writer.sv
// Directed bench for m_sdram_line_writer on a reduced 8x5 frame with a reference address/data model.
module tb_m_sdram_line_writer;
  import sdram_fb_pkg::*;

  localparam logic [10:0] HP   = 11'd8;
  localparam logic [10:0] VL   = 11'd5;
  localparam logic [1:0]  BANK = 2'd2;

  logic   clk = 1'b0;
  logic   rst, frame_start, pix_valid, pix_ready, frame_done;
  pixel_t pix_data;

  m_sdram_line_writer_if bus_if ();

  m_sdram_line_writer #(
    .H_PIXELS(HP), .V_LINES(VL), .SDRAM_BANK(BANK), .FIFO_DEPTH(32)
  ) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_data(pix_data),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .frame_done(frame_done), .bus(bus_if)
  );

  always #5 clk = ~clk;

  int   total = 0, bad = 0;
  int   pix_idx = 0, px_out = 0, exp_row = 0, exp_col = 0;
  int   fd_cnt = 0, xfers = 0, pulses = 0, fd_seen = 0;
  bit   active = 1'b0;
  logic prev_serial = 1'b0;

  function automatic logic [15:0] pv(input int k);
    logic [31:0] t;
    t = k * 37 + 32'd256;
    return t[15:0];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, pix_ready, 1'b0);
    chk({tag, "_data"}, bus_if.DATA, 16'h0000);
    chk({tag, "_addr"}, bus_if.DATA_addr, 24'h000000);
    chk({tag, "_valid"}, bus_if.DATA_out_valid, 1'b0);
    chk({tag, "_serial"}, bus_if.Serial_access, 1'b0);
    chk({tag, "_fdone"}, frame_done, 1'b0);
  endtask

  // one clock: check outputs against the model, then advance the model by this cycle's handshakes
  task automatic tick();
    logic        exp_fd, acc, xf;
    logic [23:0] ea;
    @(negedge clk);
    exp_fd = (fd_cnt == 1);
    ea = {BANK, 11'(exp_row), 11'(exp_col)};
    chk("frame_done", frame_done, exp_fd);
    chk("pix_ready", pix_ready, active && ((pix_idx - px_out) < 32));
    if (bus_if.DATA_out_valid) begin
      chk("data", bus_if.DATA, pv(px_out));
      chk("addr", bus_if.DATA_addr, ea);
      chk("serial_when_valid", bus_if.Serial_access, 1'b1);
    end
    if (pix_idx == px_out) chk("underflow_valid", bus_if.DATA_out_valid, 1'b0);
    if (active && exp_col != 0) chk("serial_midline", bus_if.Serial_access, 1'b1);
    if (exp_fd) begin
      chk("frame_xfers", xfers, int'(HP) * int'(VL));
      chk("serial_pulses", pulses, int'(VL));
      fd_seen++;
    end
    if (bus_if.Serial_access && !prev_serial) pulses++;
    prev_serial = bus_if.Serial_access;
    acc = pix_valid && pix_ready;
    xf  = bus_if.DATA_out_valid && bus_if.DATA_ack;
    if (fd_cnt > 0) fd_cnt--;
    if (fd_cnt == 1) active = 1'b0;
    if (xf) begin
      px_out++;
      xfers++;
      if (exp_row == int'(VL) - 1 && exp_col == int'(HP) - 1) fd_cnt = 2;
      if (exp_col == int'(HP) - 1) begin
        exp_col = 0;
        exp_row = (exp_row == int'(VL) - 1) ? 0 : exp_row + 1;
      end else begin
        exp_col++;
      end
    end
    if (acc) pix_idx++;
    if (frame_start) begin
      if (active) begin
        px_out = pix_idx;
        exp_row = 0;
        exp_col = 0;
        fd_cnt = 0;
      end
      xfers = 0;
      pulses = 0;
      active = 1'b1;
    end
    if (rst) begin
      active = 1'b0;
      px_out = pix_idx;
      exp_row = 0;
      exp_col = 0;
      fd_cnt = 0;
      xfers = 0;
    end
    @(posedge clk);
    #1;
    pix_data = pv(pix_idx);
  endtask

  task automatic run_frame(input bit rand_ack);
    int start, budget;
    start = fd_seen;
    budget = 600;
    pix_valid = 1'b1;
    while (fd_seen == start && budget > 0) begin
      bus_if.DATA_ack = rand_ack ? 1'($urandom_range(0, 1)) : 1'b1;
      tick();
      budget--;
    end
    chk("frame_end_seen", fd_seen - start, 1);
    bus_if.DATA_ack = 1'b0;
  endtask

  task automatic run_to(input int r, input int c);
    int budget;
    budget = 300;
    pix_valid = 1'b1;
    bus_if.DATA_ack = 1'b1;
    while (!(exp_row == r && exp_col == c) && budget > 0) begin
      tick();
      budget--;
    end
    chk("reach_position", (exp_row == r && exp_col == c), 1'b1);
  endtask

  task automatic start_frame();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    frame_start = 1'b0;
    pix_valid = 1'b0;
    bus_if.DATA_ack = 1'b0;
    pix_data = pv(0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_all_zero("reset");

    // pixels offered while idle are refused
    pix_valid = 1'b1;
    tick();
    tick();
    chk("idle_ready", pix_ready, 1'b0);

    // full frame with continuous ack
    pix_valid = 1'b0;
    start_frame();
    run_frame(1'b0);

    // input gaps mid-line: start, immediately restart to get an empty FIFO, then starve it
    pix_valid = 1'b0;
    start_frame();
    start_frame();
    bus_if.DATA_ack = 1'b1;
    pix_valid = 1'b1;
    repeat (5) tick();
    pix_valid = 1'b0;
    repeat (10) tick();
    chk("gap_valid", bus_if.DATA_out_valid, 1'b0);
    chk("gap_serial", bus_if.Serial_access, 1'b1);
    run_frame(1'b0);

    // random controller back-pressure
    start_frame();
    run_frame(1'b1);

    // controller stalls long enough for the FIFO to fill
    start_frame();
    pix_valid = 1'b1;
    bus_if.DATA_ack = 1'b0;
    repeat (40) tick();
    chk("stall_ready", pix_ready, 1'b0);
    chk("stall_valid", bus_if.DATA_out_valid, 1'b1);
    run_frame(1'b0);

    // restart in the middle of row 3; the pixel offered with frame_start is dropped
    start_frame();
    run_to(3, 4);
    bus_if.DATA_ack = 1'b0;
    pix_valid = 1'b1;
    start_frame();
    chk("restart_serial", bus_if.Serial_access, 1'b0);
    chk("restart_valid", bus_if.DATA_out_valid, 1'b0);
    run_frame(1'b0);

    // reset in the middle of a line
    start_frame();
    run_to(1, 2);
    rst = 1'b1;
    pix_valid = 1'b0;
    bus_if.DATA_ack = 1'b0;
    tick();
    rst = 1'b0;
    chk_all_zero("midreset");
    pix_valid = 1'b1;
    repeat (3) tick();
    chk("post_reset_ready", pix_ready, 1'b0);
    start_frame();
    run_frame(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
